// File: rtl/div_issue.sv
// Issue/sequencing wrapper around a fixed-latency 32-bit divider.
// Define DIV_ISSUE_FASTPATH_EN to answer divide-by-zero and signed overflow without the divider.
module div_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_ov,
    output logic [32:0] div_src1,
    output logic [31:0] div_src2,
    output logic        div_start,
    output logic        div_mod,
    output logic        div_revert,
    input  logic [31:0] div_result,
    input  logic        div_ov
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [5:0] LAST_WAIT = 6'd33;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        sov_q;

    logic        s_d;
    logic        sa_d;
    logic        sb_d;
    logic        sov_d;
    logic        fast_d;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic        ov_d;

    assign s_d     = req_op[0];
    assign sa_d    = s_d & req_a[31];
    assign sb_d    = s_d & req_b[31];
    assign mag_a_d = sa_d ? (~req_a + 32'd1) : req_a;
    assign mag_b_d = sb_d ? (~req_b + 32'd1) : req_b;
    assign sov_d   = s_d & (req_a == 32'h8000_0000)
                   & (req_b == 32'hFFFF_FFFF);

`ifdef DIV_ISSUE_FASTPATH_EN
    assign fast_d = (req_b == 32'd0) | sov_d;
`else
    assign fast_d = 1'b0;
`endif

    assign ov_d = div_ov | sov_q;

    // Gated by reset so the block never advertises readiness while held.
    assign req_ready = (state_q == IDLE) & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            sov_q      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'd0;
            rsp_ov     <= 1'b0;
            div_src1   <= 33'd0;
            div_src2   <= 32'd0;
            div_start  <= 1'b0;
            div_mod    <= 1'b0;
            div_revert <= 1'b0;
        end else begin
            div_start <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        div_src1   <= {1'b0, mag_a_d};
                        div_src2   <= mag_b_d;
                        div_mod    <= req_op[1];
                        div_revert <= req_op[1] ? sa_d : (sa_d ^ sb_d);
                        sov_q      <= sov_d;
                        cnt_q      <= 6'd0;
                        if (fast_d) begin
                            state_q    <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= 32'd0;
                            rsp_ov     <= 1'b1;
                        end else begin
                            state_q   <= START;
                            div_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    state_q <= WAIT;
                    cnt_q   <= 6'd0;
                end
                WAIT: begin
                    // Completion is purely latency-based.
                    if (cnt_q == LAST_WAIT) begin
                        state_q    <= RESP;
                        cnt_q      <= 6'd0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= ov_d ? 32'd0 : div_result;
                        rsp_ov     <= ov_d;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q   <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
